spis: RTL and testbench



---
 rtl/spis_pkg.sv | 34 +++
 rtl/spis_sync.sv | 38 +++
 rtl/spis.sv | 190 +++++++++++++++++++
 tb/tb_spis.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spis_pkg.sv
// spis_pkg: shared definitions for the SPI responder.
//   - bus register addresses
//   - ctrl write bit positions and status read bit positions
//   - default idle word shifted out when nothing is queued
//   - FSM state type and frame-length helper
package spis_pkg;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_WIDE    = 2;
  localparam int CTRL_CLR_OVR = 3;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_RX_FULL  = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_OVR      = 3;

  localparam logic [31:0] IDLE_WORD_DEFAULT = 32'hFFFF_FFFF;

  localparam int CNT_W = 6;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  // Bits per word: 32 in wide mode, 8 otherwise.
  function automatic logic [CNT_W-1:0] frame_len(input logic wide);
    return wide ? CNT_W'(32) : CNT_W'(8);
  endfunction

endpackage

// File: rtl/spis_sync.sv
// spis_sync: STAGES-deep synchronizer for one asynchronous input, with
// single-cycle rise/fall pulses derived from the synchronized level.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   async_in   : asynchronous input
//   rise, fall : one-clk pulses on synchronized rising/falling edges
// RESET_VAL sets the assumed idle level so that reset release on an idle
// line does not produce a spurious edge.
module spis_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_reg;
  logic              prev_reg;
  logic              level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_reg <= {STAGES{RESET_VAL}};
      prev_reg  <= RESET_VAL;
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], async_in};
      prev_reg  <= level;
    end
  end

  assign level = chain_reg[STAGES-1];
  assign rise  = level & ~prev_reg;
  assign fall  = ~level & prev_reg;

endmodule

// File: rtl/spis.sv
// spis: SPI mode-0 responder with a two-register CPU bus interface.
// Ports:
//   clk, rst_n         : system clock, asynchronous active-low reset
//   stb, we, addr      : bus strobe, write enable, register select (0 data, 1 ctrl/status)
//   data_in, data_out  : bus write data, combinational read data
//   ack                : bus acknowledge (zero wait states)
//   irq                : receive word available
//   ss_n, sclk, mosi   : asynchronous SPI inputs from the external master
//   miso, miso_en      : SPI data out and its pad output enable
module spis
  import spis_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] IDLE_WORD   = IDLE_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stb,
  input  logic        we,
  input  logic        addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        irq,
  input  logic        ss_n,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_en
);

  state_t state_reg, state_next;

  logic             en_reg, wide_reg, frame_wide_reg;
  logic [31:0]      tx_buf_reg, rx_buf_reg;
  logic             tx_full_reg, rx_full_reg, ovr_reg;
  logic [30:0]      tx_shift_reg;   // bit 31 of a loaded word goes straight to miso
  logic [30:0]      rx_shift_reg;   // final bit is taken from mosi directly on completion
  logic [CNT_W-1:0] count_reg;
  logic             miso_reg, miso_en_reg;

  logic ss_rise, ss_fall, sclk_rise, sclk_fall;
  logic [SYNC_STAGES-1:0] mosi_chain_reg;
  logic mosi_sync;

  logic start, abort;
  logic wr_ctrl, wr_data, rd_data;
  logic [31:0] load_word, rx_word;
  logic [CNT_W-1:0] len;
  logic word_done, rx_accept;

  // ss_n idles high, sclk idles low (mode 0)
  spis_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst_n(rst_n), .async_in(ss_n), .rise(ss_rise), .fall(ss_fall)
  );

  spis_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .async_in(sclk), .rise(sclk_rise), .fall(sclk_fall)
  );

  // mosi gets the same depth as sclk so the sampled bit lines up with the rise pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_chain_reg <= '0;
    else        mosi_chain_reg <= {mosi_chain_reg[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_sync = mosi_chain_reg[SYNC_STAGES-1];

  assign wr_ctrl = stb & we & (addr == ADDR_CTRL);
  assign wr_data = stb & we & (addr == ADDR_DATA);
  assign rd_data = stb & ~we & (addr == ADDR_DATA);

  assign load_word = tx_full_reg ? tx_buf_reg : IDLE_WORD;
  assign len       = frame_len(frame_wide_reg);
  assign word_done = (count_reg + CNT_W'(1)) == len;
  assign rx_word   = frame_wide_reg ? {rx_shift_reg, mosi_sync}
                                    : {24'h0, rx_shift_reg[6:0], mosi_sync};
  // A read in the completion cycle frees the buffer in time for the new word.
  assign rx_accept = ~rx_full_reg | rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (ss_fall && en_reg) begin
          state_next = ST_SHIFT;
          start      = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (ss_rise || !en_reg) begin
          state_next = ST_IDLE;
          abort      = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_reg         <= 1'b0;
      wide_reg       <= 1'b0;
      frame_wide_reg <= 1'b0;
      tx_buf_reg     <= '0;
      rx_buf_reg     <= '0;
      tx_full_reg    <= 1'b0;
      rx_full_reg    <= 1'b0;
      ovr_reg        <= 1'b0;
      tx_shift_reg   <= '0;
      rx_shift_reg   <= '0;
      count_reg      <= '0;
      miso_reg       <= 1'b0;
      miso_en_reg    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en_reg   <= data_in[CTRL_EN];
        wide_reg <= data_in[CTRL_WIDE];
        if (data_in[CTRL_CLR_OVR]) ovr_reg <= 1'b0;
      end
      if (rd_data) rx_full_reg <= 1'b0;

      if (start) begin
        frame_wide_reg <= wide_reg;
        tx_shift_reg   <= load_word[30:0];
        tx_full_reg    <= 1'b0;
        count_reg      <= '0;
        miso_en_reg    <= 1'b1;
        miso_reg       <= wide_reg ? load_word[31] : load_word[7];
      end else if (abort) begin
        miso_en_reg <= 1'b0;
        miso_reg    <= 1'b0;
      end else if (state_reg == ST_SHIFT) begin
        if (sclk_rise) begin
          rx_shift_reg <= {rx_shift_reg[29:0], mosi_sync};
          count_reg    <= count_reg + CNT_W'(1);
          if (word_done) begin
            if (rx_accept) begin
              rx_buf_reg  <= rx_word;
              rx_full_reg <= 1'b1;
            end else begin
              ovr_reg <= 1'b1;
            end
          end
        end else if (sclk_fall) begin
          if (count_reg == len) begin
            // word boundary: next word starts without leaving the frame
            tx_shift_reg <= load_word[30:0];
            tx_full_reg  <= 1'b0;
            count_reg    <= '0;
            miso_reg     <= frame_wide_reg ? load_word[31] : load_word[7];
          end else begin
            tx_shift_reg <= {tx_shift_reg[29:0], 1'b0};
            miso_reg     <= frame_wide_reg ? tx_shift_reg[30] : tx_shift_reg[6];
          end
        end
      end

      // Placed last so a same-cycle write survives a shifter load.
      if (wr_data) begin
        tx_buf_reg  <= data_in;
        tx_full_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    data_out = '0;
    if (addr == ADDR_DATA) begin
      data_out = rx_buf_reg;
    end else begin
      data_out[STAT_BUSY]     = (state_reg == ST_SHIFT);
      data_out[STAT_RX_FULL]  = rx_full_reg;
      data_out[STAT_TX_EMPTY] = ~tx_full_reg;
      data_out[STAT_OVR]      = ovr_reg;
    end
  end

  assign ack     = stb;
  assign irq     = rx_full_reg;
  assign miso    = miso_reg;
  assign miso_en = miso_en_reg;

endmodule

// File: tb/tb_spis.sv
module tb_spis;

  localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, we = 1'b0, addr = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        ack, irq, miso, miso_en;
  logic        ss_n = 1'b1, sclk = 1'b0, mosi = 1'b0;

  always #5 clk = ~clk;

  spis #(.SYNC_STAGES(2), .IDLE_WORD(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst_n(rst_n), .stb(stb), .we(we), .addr(addr),
    .data_in(data_in), .data_out(data_out), .ack(ack), .irq(irq),
    .ss_n(ss_n), .sclk(sclk), .mosi(mosi), .miso(miso), .miso_en(miso_en)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard: words expected in rx_buf each time irq rises
  logic [31:0] exp_rx[$];

  // reference model of the register-level behaviour
  bit          m_tx_valid, m_rx_full, m_ovr, m_wide;
  logic [31:0] m_tx_word, m_rx_buf;

  task automatic model_reset();
    m_tx_valid = 0; m_rx_full = 0; m_ovr = 0; m_wide = 0;
    m_tx_word = '0; m_rx_buf = '0;
    exp_rx.delete();
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // monitor: pops and compares whenever the DUT raises irq
  initial begin
    logic        irq_q;
    logic [31:0] e;
    irq_q = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && irq && !irq_q) begin
        if (exp_rx.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx_word: irq rose with data %h, none expected", data_out);
        end else begin
          e = exp_rx.pop_front();
          check("rx_word", data_out, e);
        end
      end
      irq_q = irq;
    end
  end

  task automatic bus_write(input logic a, input logic [31:0] d);
    @(negedge clk);
    stb = 1; we = 1; addr = a; data_in = d;
    @(negedge clk);
    stb = 0; we = 0; addr = 0; data_in = '0;
  endtask

  task automatic bus_read(input logic a, output logic [31:0] d);
    @(negedge clk);
    stb = 1; we = 0; addr = a;
    #1;
    d = data_out;
    check("ack", {31'b0, ack}, 32'd1);
    @(negedge clk);
    stb = 0; addr = 0;
  endtask

  task automatic write_ctrl(input logic [31:0] d);
    bus_write(1'b1, d);
    m_wide = d[2];
    if (d[3]) m_ovr = 0;
  endtask

  task automatic write_tx(input logic [31:0] d);
    bus_write(1'b0, d);
    m_tx_valid = 1; m_tx_word = d;
  endtask

  task automatic check_status(input string name);
    logic [31:0] d;
    bus_read(1'b1, d);
    check(name, d, {28'h0, m_ovr, ~m_tx_valid, m_rx_full, 1'b0});
  endtask

  task automatic read_data(input string name);
    logic [31:0] d;
    bus_read(1'b0, d);
    check(name, d, m_rx_buf);
    m_rx_full = 0;
  endtask

  // Mode-0 master: mosi changes with the falling edge, miso sampled just before the rise.
  task automatic spi_bits(input int nbits, input int width, input logic [31:0] mo,
                          input bit rd_last, output logic [31:0] mi, output logic [31:0] rdv);
    mi = '0; rdv = '0;
    for (int k = 0; k < nbits; k++) begin
      mosi = mo[width-1-k];
      repeat (4) @(negedge clk);
      mi = {mi[30:0], miso};
      sclk = 1;
      if (rd_last && k == nbits - 1) begin
        // the rise becomes visible inside the DUT 3 clk later; read lands on that cycle
        repeat (2) @(negedge clk);
        stb = 1; we = 0; addr = 0;
        #1 rdv = data_out;
        @(negedge clk);
        stb = 0;
        @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      sclk = 0;
    end
  endtask

  task automatic do_frame(input int nwords, input logic [31:0] mo0, input logic [31:0] mo1,
                          input bit rd_last);
    int          n;
    logic [31:0] mask, mo, exp_miso, rxw, got, rdv, old;
    bit          last_rd;
    n    = m_wide ? 32 : 8;
    mask = m_wide ? 32'hFFFF_FFFF : 32'h0000_00FF;
    ss_n = 0;
    repeat (6) @(negedge clk);
    for (int w = 0; w < nwords; w++) begin
      mo       = (w == 0) ? mo0 : mo1;
      exp_miso = (m_tx_valid ? m_tx_word : IDLE) & mask;
      m_tx_valid = 0;
      rxw      = mo & mask;
      last_rd  = rd_last && (w == nwords - 1);
      old      = m_rx_buf;
      if (last_rd) begin
        m_rx_buf = rxw; m_rx_full = 1;
      end else if (!m_rx_full) begin
        m_rx_full = 1; m_rx_buf = rxw;
        exp_rx.push_back(rxw);
      end else begin
        m_ovr = 1;
      end
      spi_bits(n, n, mo, last_rd, got, rdv);
      check("miso_word", got, exp_miso);
      if (last_rd) check("read_on_completion", rdv, old);
    end
    m_tx_valid = 0;  // trailing fall reloads the shifter from any queued word
    repeat (4) @(negedge clk);
    ss_n = 1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    logic [31:0] got, rdv, r;
    bit          wbit;
    int          nw;

    model_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    check("reset_miso", {31'b0, miso}, 32'd0);
    check("reset_miso_en", {31'b0, miso_en}, 32'd0);
    check("reset_irq", {31'b0, irq}, 32'd0);
    check("reset_rx_buf", data_out, 32'd0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    check_status("reset_status");

    // reset in the middle of a frame
    write_ctrl(32'h1);
    write_tx(32'hA5);
    ss_n = 0;
    repeat (6) @(negedge clk);
    spi_bits(5, 8, 32'h5A, 0, got, rdv);
    rst_n = 0;
    #1;
    check("midrst_miso", {31'b0, miso}, 32'd0);
    check("midrst_miso_en", {31'b0, miso_en}, 32'd0);
    check("midrst_irq", {31'b0, irq}, 32'd0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    spi_bits(3, 8, 32'hFF, 0, got, rdv);
    repeat (4) @(negedge clk);
    ss_n = 1;
    repeat (6) @(negedge clk);
    check("midrst_irq_after", {31'b0, irq}, 32'd0);
    check_status("midrst_status");

    // narrow exchange
    write_ctrl(32'h1);
    write_tx(32'hA5);
    do_frame(1, 32'h3C, 32'h0, 0);
    check_status("narrow_status");
    read_data("narrow_data");

    // wide exchange
    write_ctrl(32'h5);
    write_tx(32'hDEADBEEF);
    do_frame(1, 32'h12345678, 32'h0, 0);
    check("wide_irq_high", {31'b0, irq}, 32'd1);
    read_data("wide_data");
    check("wide_irq_low", {31'b0, irq}, 32'd0);

    // two words without reading, second not queued -> idle word and overrun
    write_tx($urandom);
    do_frame(2, $urandom, $urandom, 0);
    check_status("ovr_status");
    write_ctrl(32'h9);
    check_status("ovr_cleared_status");
    read_data("ovr_first_word_kept");

    // abort after 13 bits of a wide word
    write_ctrl(32'h5);
    ss_n = 0;
    repeat (6) @(negedge clk);
    spi_bits(13, 32, $urandom, 0, got, rdv);
    repeat (4) @(negedge clk);
    ss_n = 1;
    repeat (6) @(negedge clk);
    check("abort_miso_en", {31'b0, miso_en}, 32'd0);
    check_status("abort_status");
    write_tx($urandom);
    do_frame(1, $urandom, 32'h0, 0);
    read_data("after_abort_data");

    // data read on the completion cycle
    do_frame(1, $urandom, 32'h0, 0);
    do_frame(1, $urandom, 32'h0, 1);
    check_status("completion_read_status");
    read_data("completion_read_new_word");

    // randomized frames
    for (int i = 0; i < 10; i++) begin
      wbit = 1'($urandom_range(0, 1));
      write_ctrl({29'h0, wbit, 2'b01});
      if ($urandom_range(0, 1) == 1) write_tx($urandom);
      nw = $urandom_range(1, 2);
      do_frame(nw, $urandom, $urandom, 0);
      check_status("rand_status");
      if ($urandom_range(0, 2) != 0 && m_rx_full) read_data("rand_data");
      if (m_ovr) begin
        write_ctrl({28'h0, 1'b1, wbit, 2'b01});
        check_status("rand_ovr_clear");
      end
    end

    repeat (4) @(negedge clk);
    r = 32'(exp_rx.size());
    check("rx_scoreboard_drained", r, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
